// File: rtl/gbuf_read_streamer_pkg.sv
// gbuf_read_streamer_pkg: shared widths, FIFO depth default and FSM encoding
// for the global-buffer read streamer.
package gbuf_read_streamer_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_LEN_W      = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned STRIDE_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gbuf_read_streamer_if.sv
// gbuf_read_streamer_if: valid/ready output stream toward PE-array staging.
//   out_data  : stream word
//   out_valid : word present
//   out_ready : consumer accepts word
//   out_last  : final word of the burst (qualified by out_valid)
// master = streamer side, slave = consumer side.
interface gbuf_read_streamer_if
    import gbuf_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/gbuf_read_streamer_stream_fifo.sv
// gbuf_read_streamer_stream_fifo: synchronous FIFO with occupancy count.
//   clk, rst      : clock, async active-high reset (flushes contents)
//   push_i/data   : write one entry
//   pop_i         : remove head entry (ignored when empty)
//   pop_data_o    : head entry
//   count_o       : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module gbuf_read_streamer_stream_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointer/count update; push and pop may coincide, even when full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i && (count_q != '0);
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Issue credit guarantees room for every returning read word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/gbuf_read_streamer.sv
// gbuf_read_streamer: burst reader for the NPU global buffer. A start pulse
// issues `length` single-word reads, absorbs the 1-cycle SRAM latency and
// streams the words in order over out_if with full backpressure.
//   clk, rst            : clock, async active-high reset
//   start               : command pulse (honoured only when idle)
//   base_addr, length   : burst command, sampled on accepted start
//   stride              : address step (only with GBUF_STREAM_STRIDE_EN)
//   busy, done          : burst in progress / one-cycle completion pulse
//   buf_ce/we/addr/rdata: global buffer read port
//   out_if              : output stream (master modport)
// Build option: define GBUF_STREAM_STRIDE_EN for the stride port; otherwise
// the address advances by 1 per word.
module gbuf_read_streamer
    import gbuf_read_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
`ifdef GBUF_STREAM_STRIDE_EN
    input  logic [STRIDE_W-1:0] stride,
`endif
    output logic                busy,
    output logic                done,
    output logic                buf_ce,
    output logic                buf_we,
    output logic [ADDR_W-1:0]   buf_addr,
    input  logic [DATA_W-1:0]   buf_rdata,
    gbuf_read_streamer_if.master out_if
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic                buf_ce_q, buf_ce_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic                buf_last_q, buf_last_d;
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   start_inc, inc;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W:0]     fifo_rdata;
    logic                out_valid_c;
    logic                credit_ok;
    logic                last_pop;

`ifdef GBUF_STREAM_STRIDE_EN
    logic [ADDR_W-1:0]   inc_q, inc_d;

    always_comb begin
        inc_d = inc_q;
        if (state_q == ST_IDLE && start) begin
            inc_d = ADDR_W'(stride);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inc_q <= '0;
        else     inc_q <= inc_d;
    end

    assign start_inc = ADDR_W'(stride);
    assign inc       = inc_q;
`else
    assign start_inc = ADDR_W'(1);
    assign inc       = ADDR_W'(1);
`endif

    // Next-state and issue logic. A read is launched only when the FIFO can
    // hold it together with the two words still in the SRAM pipeline.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        buf_ce_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_last_d  = 1'b0;
        done_d      = 1'b0;
        credit_ok   = (CRD_W'(fifo_count) + CRD_W'(buf_ce_q) + CRD_W'(pend_q))
                      < CRD_W'(FIFO_DEPTH);
        last_pop    = out_valid_c && out_if.out_ready && fifo_rdata[DATA_W];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        buf_ce_d    = 1'b1;
                        buf_addr_d  = base_addr;
                        addr_d      = base_addr + start_inc;
                        issue_cnt_d = length - LEN_W'(1);
                        buf_last_d  = (length == LEN_W'(1));
                        state_d     = (length == LEN_W'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    buf_ce_d    = 1'b1;
                    buf_addr_d  = addr_q;
                    addr_d      = addr_q + inc;
                    issue_cnt_d = issue_cnt_q - LEN_W'(1);
                    if (issue_cnt_q == LEN_W'(1)) begin
                        buf_last_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_pop && !buf_ce_q && !pend_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pend_d      = buf_ce_q;
        pend_last_d = buf_last_q;
        busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            buf_ce_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_last_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            buf_ce_q    <= buf_ce_d;
            buf_addr_q  <= buf_addr_d;
            buf_last_q  <= buf_last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Word returned by the SRAM one cycle after issue is tagged with its last bit.
    gbuf_read_streamer_stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pend_q),
        .push_data_i ({pend_last_q, buf_rdata}),
        .pop_i       (out_if.out_ready),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count)
    );

    assign out_valid_c      = (fifo_count != '0);
    assign out_if.out_valid = out_valid_c;
    assign out_if.out_data  = fifo_rdata[DATA_W-1:0];
    assign out_if.out_last  = out_valid_c && fifo_rdata[DATA_W];

    assign busy     = busy_q;
    assign done     = done_q;
    assign buf_ce   = buf_ce_q;
    assign buf_we   = 1'b0;
    assign buf_addr = buf_addr_q;

endmodule

// File: tb/tb_gbuf_read_streamer.sv
// tb_gbuf_read_streamer: directed bench for gbuf_read_streamer with an
// SRAM model returning a known function of the address.
module tb_gbuf_read_streamer;
    localparam int DEPTH  = 4;
    localparam int BUDGET = 300;

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        logic [15:0] strd;
        int          mode;      // 0: ready high, 1: toggling, 2: 3 high / 2 low
        int          exp_done;  // done cycle after accepting edge, -1 = unchecked
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] length;
`ifdef GBUF_STREAM_STRIDE_EN
    logic [15:0] stride;
`endif
    logic        busy, done, buf_ce, buf_we;
    logic [31:0] buf_addr;
    logic [15:0] buf_rdata;

    int n_tests;
    int n_fail;
    vec_t vecs[8];

    gbuf_read_streamer_if #(.DATA_W(16)) sif ();

    gbuf_read_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef GBUF_STREAM_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .buf_ce    (buf_ce),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_rdata (buf_rdata),
        .out_if    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [31:0] a);
        return a[15:0] + 16'h0090;
    endfunction

    // Global buffer with 1-cycle read latency.
    always @(posedge clk) begin
        if (buf_ce) buf_rdata <= model(buf_addr);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        logic [31:0] step;
        logic [31:0] exp_addr;
        int          issued, popped, first_valid, done_cyc;
        logic        pv, pr, pl;
        logic [15:0] pdata;
`ifdef GBUF_STREAM_STRIDE_EN
        step = 32'(v.strd);
`else
        step = 32'd1;
`endif
        issued = 0; popped = 0; first_valid = -1; done_cyc = -1;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pdata = '0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
`ifdef GBUF_STREAM_STRIDE_EN
        stride    = v.strd;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= BUDGET && done_cyc < 0; cyc++) begin
            case (v.mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = (cyc % 2) == 1;
                default: sif.out_ready = (cyc % 5) < 3;
            endcase
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", busy, v.len != 16'd0);
            if (pv && !pr) begin
                check("hold_valid", sif.out_valid, 1);
                check("hold_data", sif.out_data, pdata);
                check("hold_last", sif.out_last, pl);
            end
            if (buf_ce) begin
                exp_addr = v.base + step * 32'(issued);
                check("buf_addr", buf_addr, exp_addr);
                issued++;
                check("credit_limit", (issued - popped) <= DEPTH, 1);
            end
            if (sif.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (sif.out_ready) begin
                    exp_addr = v.base + step * 32'(popped);
                    check("out_data", sif.out_data, model(exp_addr));
                    check("out_last", sif.out_last, popped == int'(v.len) - 1);
                    popped++;
                end
            end
            if (done) done_cyc = cyc;
            pv = sif.out_valid; pr = sif.out_ready; pdata = sif.out_data; pl = sif.out_last;
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles (base 0x%0h len %0d)", BUDGET, v.base, v.len);
        end
        if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
        if (v.mode == 0 && v.len != 16'd0) check("first_valid_cycle", first_valid, 3);
        check("issue_count", issued, int'(v.len));
        check("word_count", popped, int'(v.len));
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int words;
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{base: 32'h10,       len: 16'd4,  strd: 16'd1, mode: 0, exp_done: 7};
        vecs[1] = '{base: 32'h0,        len: 16'd0,  strd: 16'd1, mode: 0, exp_done: 1};
        vecs[2] = '{base: 32'h100,      len: 16'd16, strd: 16'd1, mode: 1, exp_done: -1};
        vecs[3] = '{base: 32'hFFFFFFFE, len: 16'd4,  strd: 16'd1, mode: 0, exp_done: 7};
        vecs[4] = '{base: 32'h20,       len: 16'd1,  strd: 16'd1, mode: 0, exp_done: 4};
        vecs[5] = '{base: 32'h40,       len: 16'd7,  strd: 16'd1, mode: 2, exp_done: -1};
        vecs[6] = '{base: 32'h0,        len: 16'd3,  strd: 16'd8, mode: 0, exp_done: 6};
        vecs[7] = '{base: 32'h300,      len: 16'd9,  strd: 16'd0, mode: 0, exp_done: 12};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
`ifdef GBUF_STREAM_STRIDE_EN
        stride = '0;
`endif
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_buf_ce", buf_ce, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_out_last", sif.out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i]);
        end

        // Reset in the middle of a 10-word burst after three words.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h200; length = 16'd10;
`ifdef GBUF_STREAM_STRIDE_EN
        stride = 16'd1;
`endif
        @(posedge clk); #1;
        start = 1'b0; sif.out_ready = 1'b1;
        words = 0;
        for (int c = 0; c < 50 && words < 3; c++) begin
            @(negedge clk);
            if (sif.out_valid && sif.out_ready) words++;
            @(posedge clk); #1;
        end
        check("midrst_words_seen", words, 3);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_buf_ce", buf_ce, 0);
        check("midrst_buf_we", buf_we, 0);
        check("midrst_buf_addr", buf_addr, 0);
        check("midrst_out_valid", sif.out_valid, 0);
        check("midrst_out_data", sif.out_data, 0);
        check("midrst_out_last", sif.out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
            check("midrst_idle_valid", sif.out_valid, 0);
            @(posedge clk); #1;
        end
        run_burst(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
